stack_ctrl: RTL
===============

# stack_ctrl

Issue-side controller for the dual-port 32x1024 push/pop stack in the in-order superscalar CPU. It accepts push/pop requests from the two issue slots each cycle and keeps its own shadow occupancy count. Pairs the stack can execute together in one cycle go out together. Infeasible pairs are split across two cycles with an issue stall. Ops that can never succeed are dropped, and sticky overflow, underflow and illegal-op flags are raised.

## Interface
Parameters:
- DEPTH, 1024, stack capacity in words
- CNT_W, 11, occupancy counter width; must hold 0..DEPTH

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- push_req0 / pop_req0  in  1  slot-0 (older instruction) push / pop request
- push_req1 / pop_req1  in  1  slot-1 (younger instruction) push / pop request
- wdata_in0 / wdata_in1  in  32  push data for slot 0 / slot 1
- clr_err  in  1  clears the sticky error flags
- push0, pop0, push1, pop1  out  1  stack port commands
- wdata0, wdata1  out  32  stack write data
- stall  out  1  issue stage must hold the current slot pair for one more cycle
- depth  out  CNT_W  shadow occupancy
- ovf, unf, ill  out  1  sticky flags: push dropped when full, pop dropped when empty, slot requested both push and pop

## Operation
- FSM states:
  - IDLE: evaluates the live requests.
  - SLOT1: replays the latched slot-1 request.
- Illegal slot: push_req and pop_req both set in one slot. Set ill and treat that slot as a no-op. Applies only in IDLE.
- Pair feasibility in IDLE, with d = depth:
  - push0+push1: needs d <= DEPTH-2.
  - pop0+pop1: needs d >= 2.
  - push0+pop1: always feasible (stack bypass, net 0).
  - pop0+push1: needs d >= 1.
- Feasible pair: drive both port commands in the same cycle and stay in IDLE.
- Infeasible pair:
  - Issue slot 0 alone if it is feasible. Otherwise drop slot 0 and set ovf or unf.
  - Latch slot 1's op and wdata_in1, assert stall, go to SLOT1.
- Single op on either slot:
  - Issue it if feasible (push needs d < DEPTH, pop needs d >= 1). Otherwise drop it and set ovf or unf.
  - A lone slot-1 op is driven on push1/pop1. A lone slot-0 op is driven on push0/pop0.
- SLOT1:
  - Evaluate the latched op against the updated depth. Issue it on push1/pop1 with wdata1 = latched data, or drop it and flag.
  - Live inputs are ignored. stall = 0. Next state is IDLE.
- Depth update on each posedge by the net of issued commands: +2, +1, 0, -1 or -2. Dropped ops contribute nothing. depth never leaves 0..DEPTH.
- Port commands that are not issued are 0. wdata0/wdata1 pass wdata_in0/wdata_in1 through in IDLE.
- Error flags:
  - Flags are sticky.
  - clr_err clears them on the next posedge.
  - A set in the same cycle as clr_err wins.

## Timing
- Port commands and stall are combinational from the state, inputs and depth. The stack samples them on the following negedge.
- depth, the state, the flags and the slot-1 latch update on posedge clk.
- Reset (rst_n low at posedge):
  - state = IDLE, depth = 0, ovf = unf = ill = 0, latch cleared.
  - All outputs are 0 while rst_n is low, including port commands and stall.
  - Reset during SLOT1 discards the latched op.
- Latency:
  - A feasible pair or single op issues in the same cycle the request is presented.
  - A split pair takes 2 cycles: slot 0 in cycle N with stall = 1, slot 1 in cycle N+1 with stall = 0.
- Boundaries:
  - At d = DEPTH-1, push+push splits: push0 issues, then the push1 replay is dropped with ovf and depth stays DEPTH.
  - At d = 1, pop+pop splits: pop0 issues, then the pop1 replay is dropped with unf.
  - At d = 0, pop0+push1 splits: pop0 is dropped with unf, then push1 issues in SLOT1.

## Test plan
- Reset, then push_req0 + push_req1 at depth 0 -> push0 = push1 = 1 same cycle, stall = 0, depth = 2 next cycle.
- Fill to depth 1023, then push_req0 + push_req1 -> cycle N: push0 = 1, stall = 1; cycle N+1: push1 = 0, ovf = 1, depth = 1024.
- depth 0, pop_req0 + push_req1 -> cycle N: unf = 1, stall = 1, no command; cycle N+1: push1 = 1 with latched data, depth = 1.
- depth 5, push_req0 + pop_req1 -> push0 = pop1 = 1, stall = 0, depth stays 5; pop_req0 + pop_req1 -> depth 3.
- push_req1 + pop_req1 at depth 4 -> ill = 1, no commands, depth 4; assert clr_err -> ill = 0 next cycle.
- Enter SLOT1, assert rst_n = 0 -> next cycle state IDLE, depth = 0, no replayed push1.

Source files
------------

// File: rtl/stack_ctrl.sv
// Issue-side controller for the dual-port push/pop stack: pairs, splits or drops
// slot ops against a shadow occupancy count and keeps sticky error flags.
module stack_ctrl #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req0,
    input  logic             pop_req0,
    input  logic             push_req1,
    input  logic             pop_req1,
    input  logic [31:0]      wdata_in0,
    input  logic [31:0]      wdata_in1,
    input  logic             clr_err,
    output logic             push0,
    output logic             pop0,
    output logic             push1,
    output logic             pop1,
    output logic [31:0]      wdata0,
    output logic [31:0]      wdata1,
    output logic             stall,
    output logic [CNT_W-1:0] depth,
    output logic             ovf,
    output logic             unf,
    output logic             ill
);

    // state | meaning
    // IDLE  | evaluate live slot requests
    // SLOT1 | replay latched slot-1 op of a split pair
    typedef enum logic {IDLE = 1'b0, SLOT1 = 1'b1} state_t;

    localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL_M2 = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] C_TWO     = CNT_W'(2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_depth;
    logic [CNT_W-1:0]   w_depth_nxt;
    logic               r_ovf, r_unf, r_ill;
    logic               r_lat_push, r_lat_pop;
    logic [31:0]        r_lat_data;

    logic w_p0, w_q0, w_p1, w_q1, w_ill0, w_ill1;
    logic w_can_push, w_can_pop, w_can_push2, w_can_pop2;
    logic w_push0, w_pop0, w_push1, w_pop1, w_stall;
    logic w_set_ovf, w_set_unf, w_set_ill, w_lat_load, w_pair_ok;
    logic [1:0] w_n_up, w_n_dn;

    // A slot asking for both push and pop is treated as a no-op.
    assign w_ill0 = push_req0 & pop_req0;
    assign w_ill1 = push_req1 & pop_req1;
    assign w_p0   = push_req0 & ~pop_req0;
    assign w_q0   = pop_req0 & ~push_req0;
    assign w_p1   = push_req1 & ~pop_req1;
    assign w_q1   = pop_req1 & ~push_req1;

    assign w_can_push  = r_depth < C_FULL;
    assign w_can_pop   = r_depth != '0;
    assign w_can_push2 = r_depth <= C_FULL_M2;
    assign w_can_pop2  = r_depth >= C_TWO;

    always_comb begin
        w_state_nxt = r_state;
        w_push0     = 1'b0;
        w_pop0      = 1'b0;
        w_push1     = 1'b0;
        w_pop1      = 1'b0;
        w_stall     = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_set_ill   = 1'b0;
        w_lat_load  = 1'b0;
        w_pair_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                w_set_ill = w_ill0 | w_ill1;
                if ((w_p0 | w_q0) && (w_p1 | w_q1)) begin
                    // push0+pop1 goes through the stack bypass, so it never overflows
                    w_pair_ok = (w_p0 & w_p1 & w_can_push2) | (w_q0 & w_q1 & w_can_pop2) |
                                (w_p0 & w_q1) | (w_q0 & w_p1 & w_can_pop);
                    if (w_pair_ok) begin
                        w_push0 = w_p0;
                        w_pop0  = w_q0;
                        w_push1 = w_p1;
                        w_pop1  = w_q1;
                    end else begin
                        w_push0     = w_p0 & w_can_push;
                        w_pop0      = w_q0 & w_can_pop;
                        w_set_ovf   = w_p0 & ~w_can_push;
                        w_set_unf   = w_q0 & ~w_can_pop;
                        w_stall     = 1'b1;
                        w_lat_load  = 1'b1;
                        w_state_nxt = SLOT1;
                    end
                end else begin
                    w_push0   = w_p0 & w_can_push;
                    w_pop0    = w_q0 & w_can_pop;
                    w_push1   = w_p1 & w_can_push;
                    w_pop1    = w_q1 & w_can_pop;
                    w_set_ovf = (w_p0 | w_p1) & ~w_can_push;
                    w_set_unf = (w_q0 | w_q1) & ~w_can_pop;
                end
            end
            SLOT1: begin
                w_push1     = r_lat_push & w_can_push;
                w_pop1      = r_lat_pop & w_can_pop;
                w_set_ovf   = r_lat_push & ~w_can_push;
                w_set_unf   = r_lat_pop & ~w_can_pop;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_n_up      = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_n_dn      = {1'b0, w_pop0} + {1'b0, w_pop1};
    assign w_depth_nxt = r_depth + CNT_W'(w_n_up) - CNT_W'(w_n_dn);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_depth    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_ill      <= 1'b0;
            r_lat_push <= 1'b0;
            r_lat_pop  <= 1'b0;
            r_lat_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_depth <= w_depth_nxt;
            // a new error in the clearing cycle survives the clear
            r_ovf   <= (r_ovf & ~clr_err) | w_set_ovf;
            r_unf   <= (r_unf & ~clr_err) | w_set_unf;
            r_ill   <= (r_ill & ~clr_err) | w_set_ill;
            if (w_lat_load) begin
                r_lat_push <= w_p1;
                r_lat_pop  <= w_q1;
                r_lat_data <= wdata_in1;
            end else if (r_state == SLOT1) begin
                r_lat_push <= 1'b0;
                r_lat_pop  <= 1'b0;
                r_lat_data <= '0;
            end
        end
    end

    assign push0  = rst_n & w_push0;
    assign pop0   = rst_n & w_pop0;
    assign push1  = rst_n & w_push1;
    assign pop1   = rst_n & w_pop1;
    assign stall  = rst_n & w_stall;
    assign wdata0 = rst_n ? wdata_in0 : '0;
    assign wdata1 = !rst_n ? '0 : ((r_state == SLOT1) ? r_lat_data : wdata_in1);
    assign depth  = rst_n ? r_depth : '0;
    assign ovf    = rst_n & r_ovf;
    assign unf    = rst_n & r_unf;
    assign ill    = rst_n & r_ill;

endmodule
